// File: rtl/osc_wave_pkg.sv
// Shared types, register map constants and the sine table generator for osc_wave_gen.
package osc_wave_pkg;

    // Geometry of the default build; the slot tag type is derived from these.
    localparam int VX_W     = 3;
    localparam int OX_W     = 2;
    localparam int PH_BITS  = 11;
    localparam int OUT_BITS = 17;

    // Waveform selector stored per oscillator.
    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_SQUARE = 2'd2,
        WAVE_TRI    = 2'd3
    } wave_e;

    // Register map: each oscillator owns a 16-byte window.
    localparam int         OSC_STRIDE = 16;
    localparam int         STRIDE_SH  = 4;
    localparam logic [3:0] REG_OFFS   = 4'd6;
    localparam logic [3:0] REG_WAVE   = 4'd7;
    localparam logic [3:0] REG_PW     = 4'd8;

    // Voice/oscillator tag that travels with every sample.
    typedef struct packed {
        logic [VX_W-1:0] vx;
        logic [OX_W-1:0] ox;
    } slot_t;

    // Quarter-wave table covers indices 0..512 inclusive so the peak is stored.
    localparam int SINE_Q_LEN = 513;

    // round(65535 * sin(pi/2 * idx/512)) evaluated with a Q30 Taylor series at elaboration.
    function automatic logic [15:0] sine_q(input int idx);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint rnd;
        x    = (longint'(idx) * 64'sd3373259426) >>> 10;
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int k = 1; k <= 10; k++) begin
            term = ((term * x2) >>> 30) / (longint'(32'sd2 * k) * longint'(32'sd2 * k + 32'sd1));
            term = -term;
            sum  = sum + term;
        end
        rnd = (sum * 64'sd65535 + 64'sd536870912) >>> 30;
        return rnd[15:0];
    endfunction

endpackage

// File: rtl/osc_wave_shaper.sv
// Phase-to-amplitude shaper: sine / saw / square / triangle, one output register stage.
module osc_wave_shaper
    import osc_wave_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [PH_BITS-1:0]         in_phase,
    input  slot_t                      in_slot,
    input  wave_e                      wave_sel,
    input  logic [7:0]                 pw,
    output logic                       out_valid,
    output slot_t                      out_slot,
    output logic signed [OUT_BITS-1:0] wave_out
);

    logic [15:0]                rom_s [0:SINE_Q_LEN-1];
    logic [9:0]                 rom_idx_s;
    logic [OUT_BITS-1:0]        sine_mag_s;
    logic [9:0]                 tri_t_s;
    logic signed [OUT_BITS-1:0] shaped_s;

    logic                       out_valid_q, out_valid_d;
    slot_t                      out_slot_q, out_slot_d;
    logic signed [OUT_BITS-1:0] wave_q, wave_d;

    // Constant quarter-wave sine ROM, one entry per index.
    for (genvar gi = 0; gi < SINE_Q_LEN; gi++) begin : g_sine_rom
        localparam logic [15:0] ENTRY = sine_q(gi);
        assign rom_s[gi] = ENTRY;
    end

    // Fold the phase into the quarter table and build all four waveforms.
    always_comb begin
        rom_idx_s  = 10'd0;
        sine_mag_s = '0;
        tri_t_s    = 10'd0;
        shaped_s   = '0;
        // Second and fourth quarters read the table backwards (512 down to 1).
        if (in_phase[9]) begin
            rom_idx_s = 10'd512 - {1'b0, in_phase[8:0]};
        end else begin
            rom_idx_s = {1'b0, in_phase[8:0]};
        end
        sine_mag_s = {1'b0, rom_s[rom_idx_s]};
        if (in_phase[10]) begin
            tri_t_s = ~in_phase[9:0];
        end else begin
            tri_t_s = in_phase[9:0];
        end
        case (wave_sel)
            WAVE_SINE: begin
                if (in_phase[10]) begin
                    shaped_s = 17'd0 - sine_mag_s;
                end else begin
                    shaped_s = sine_mag_s;
                end
            end
            // (p - 1024) << 6: invert the MSB to recentre, then shift.
            WAVE_SAW:    shaped_s = {~in_phase[10], in_phase[9:0], 6'b000000};
            WAVE_SQUARE: shaped_s = (in_phase[10:3] < pw) ? 17'h0FFFF : 17'h10000;
            // (t << 7) - 65536 folds into an MSB inversion of t.
            WAVE_TRI:    shaped_s = {~tri_t_s[9], tri_t_s[8:0], 7'b0000000};
            default:     shaped_s = '0;
        endcase
    end

    // Next-state for the output stage; data holds across gaps.
    always_comb begin
        out_valid_d = in_valid;
        out_slot_d  = out_slot_q;
        wave_d      = wave_q;
        if (in_valid) begin
            out_slot_d = in_slot;
            wave_d     = shaped_s;
        end else begin
            out_slot_d = out_slot_q;
        end
    end

    // Output register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_slot_q  <= '0;
            wave_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_slot_q  <= out_slot_d;
            wave_q      <= wave_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_slot  = out_slot_q;
    assign wave_out  = wave_q;

endmodule

// File: rtl/osc_wave_gen.sv
// Time-multiplexed multi-waveform oscillator: slot counter, per-slot phase accumulators,
// per-oscillator offset/waveform/pulse-width registers and a 3-stage pipeline.
module osc_wave_gen
    import osc_wave_pkg::*;
#(
    parameter int VOICES  = 8,
    parameter int V_OSC   = 4,
    parameter int V_WIDTH = 3,
    parameter int O_WIDTH = 2,
    parameter int ACC_W   = 24,
    parameter int PH_W    = 11,
    parameter int OUT_W   = 17
) (
    input  logic                    sCLK_XVXOSC,
    input  logic                    reset_reg,
    input  logic                    slot_valid_in,
    input  logic [ACC_W-1:0]        pitch_in,
    input  logic                    sync_in,
    input  logic signed [PH_W-1:0]  modulation,
    output logic [V_WIDTH-1:0]      cur_vx,
    output logic [O_WIDTH-1:0]      cur_ox,
    input  logic                    reg_wr,
    input  logic                    reg_rd,
    input  logic [6:0]              reg_adr,
    input  logic [7:0]              reg_wdata,
    output logic [7:0]              reg_rdata,
    output logic                    reg_rd_valid,
    output logic                    out_valid,
    output logic [V_WIDTH-1:0]      out_vx,
    output logic [O_WIDTH-1:0]      out_ox,
    output logic signed [OUT_W-1:0] wave_out
);

    localparam int S      = VOICES * V_OSC;
    localparam int SLOT_W = V_WIDTH + O_WIDTH;

    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [ACC_W-1:0]      acc_q [S];
    logic [ACC_W-1:0]      acc_d [S];
    logic signed [7:0]     offs_q [V_OSC];
    logic signed [7:0]     offs_d [V_OSC];
    wave_e                 wave_q [V_OSC];
    wave_e                 wave_d [V_OSC];
    logic [7:0]            pw_q [V_OSC];
    logic [7:0]            pw_d [V_OSC];
    logic [7:0]            rdata_q, rdata_d;
    logic                  rd_valid_q, rd_valid_d;

    logic                  s0_valid_q, s0_valid_d;
    logic [PH_W-1:0]       s0_top_q, s0_top_d;
    logic [PH_W-1:0]       s0_mod_q, s0_mod_d;
    slot_t                 s0_slot_q, s0_slot_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [PH_W-1:0]       s1_phase_q, s1_phase_d;
    slot_t                 s1_slot_q, s1_slot_d;

    logic                  osc_hit_s;
    logic [O_WIDTH-1:0]    osc_idx_s;
    logic [3:0]            reg_off_s;
    logic [7:0]            rd_val_s;
    logic [PH_W-1:0]       offs_ext_s;
    slot_t                 shp_slot_s;

    // Register decode, read mux and write path.
    always_comb begin
        osc_hit_s  = ({29'd0, reg_adr[6:STRIDE_SH]} < 32'(V_OSC));
        osc_idx_s  = reg_adr[STRIDE_SH +: O_WIDTH];
        reg_off_s  = reg_adr[STRIDE_SH-1:0];
        rd_val_s   = 8'h00;
        offs_d     = offs_q;
        wave_d     = wave_q;
        pw_d       = pw_q;
        if (osc_hit_s) begin
            case (reg_off_s)
                REG_OFFS: rd_val_s = offs_q[osc_idx_s];
                REG_WAVE: rd_val_s = {6'b000000, wave_q[osc_idx_s]};
                REG_PW:   rd_val_s = pw_q[osc_idx_s];
                default:  rd_val_s = 8'h00;
            endcase
        end else begin
            rd_val_s = 8'h00;
        end
        if (reg_wr && osc_hit_s) begin
            case (reg_off_s)
                REG_OFFS: offs_d[osc_idx_s] = reg_wdata;
                REG_WAVE: wave_d[osc_idx_s] = wave_e'(reg_wdata[1:0]);
                REG_PW:   pw_d[osc_idx_s]   = reg_wdata;
                default:  pw_d[osc_idx_s]   = pw_q[osc_idx_s];
            endcase
        end else begin
            pw_d = pw_q;
        end
        // Read uses the pre-write value, so a same-cycle write/read returns old data.
        rd_valid_d = reg_rd;
        if (reg_rd) begin
            rdata_d = rd_val_s;
        end else begin
            rdata_d = 8'h00;
        end
    end

    // Stage 0: accumulate the current slot and latch its old phase and tags.
    always_comb begin
        slot_d     = slot_q;
        acc_d      = acc_q;
        s0_valid_d = slot_valid_in;
        s0_top_d   = s0_top_q;
        s0_mod_d   = s0_mod_q;
        s0_slot_d  = s0_slot_q;
        if (slot_valid_in) begin
            acc_d[slot_q] = sync_in ? '0 : acc_q[slot_q] + pitch_in;
            s0_top_d      = acc_q[slot_q][ACC_W-1 -: PH_W];
            s0_mod_d      = modulation;
            s0_slot_d     = slot_t'(slot_q);
            if (slot_q == SLOT_W'(S - 1)) begin
                slot_d = '0;
            end else begin
                slot_d = slot_q + SLOT_W'(1);
            end
        end else begin
            slot_d = slot_q;
        end
    end

    // Stage 1: phase = acc top + modulation + (offset << 3), wrapping in PH_W bits.
    always_comb begin
        offs_ext_s = PH_W'($signed({offs_q[s0_slot_q.ox], 3'b000}));
        s1_valid_d = s0_valid_q;
        s1_phase_d = s1_phase_q;
        s1_slot_d  = s1_slot_q;
        if (s0_valid_q) begin
            s1_phase_d = s0_top_q + s0_mod_q + offs_ext_s;
            s1_slot_d  = s0_slot_q;
        end else begin
            s1_slot_d  = s1_slot_q;
        end
    end

    // Slot counter, accumulators and per-oscillator registers.
    always_ff @(posedge sCLK_XVXOSC or posedge reset_reg) begin
        if (reset_reg) begin
            slot_q     <= '0;
            rdata_q    <= 8'h00;
            rd_valid_q <= 1'b0;
            for (int i = 0; i < S; i++) begin
                acc_q[i] <= '0;
            end
            for (int o = 0; o < V_OSC; o++) begin
                offs_q[o] <= 8'sd0;
                wave_q[o] <= WAVE_SINE;
                pw_q[o]   <= 8'h00;
            end
        end else begin
            slot_q     <= slot_d;
            acc_q      <= acc_d;
            offs_q     <= offs_d;
            wave_q     <= wave_d;
            pw_q       <= pw_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Pipeline registers for stages 0 and 1; reset drops samples in flight.
    always_ff @(posedge sCLK_XVXOSC or posedge reset_reg) begin
        if (reset_reg) begin
            s0_valid_q <= 1'b0;
            s0_top_q   <= '0;
            s0_mod_q   <= '0;
            s0_slot_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_phase_q <= '0;
            s1_slot_q  <= '0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_top_q   <= s0_top_d;
            s0_mod_q   <= s0_mod_d;
            s0_slot_q  <= s0_slot_d;
            s1_valid_q <= s1_valid_d;
            s1_phase_q <= s1_phase_d;
            s1_slot_q  <= s1_slot_d;
        end
    end

    osc_wave_shaper u_shaper (
        .clk       (sCLK_XVXOSC),
        .rst       (reset_reg),
        .in_valid  (s1_valid_q),
        .in_phase  (s1_phase_q),
        .in_slot   (s1_slot_q),
        .wave_sel  (wave_q[s1_slot_q.ox]),
        .pw        (pw_q[s1_slot_q.ox]),
        .out_valid (out_valid),
        .out_slot  (shp_slot_s),
        .wave_out  (wave_out)
    );

    assign cur_vx       = slot_q[SLOT_W-1:O_WIDTH];
    assign cur_ox       = slot_q[O_WIDTH-1:0];
    assign out_vx       = shp_slot_s.vx;
    assign out_ox       = shp_slot_s.ox;
    assign reg_rdata    = rdata_q;
    assign reg_rd_valid = rd_valid_q;

endmodule
